// File: rtl/clock_pkg.sv
// Shared types and constants for the clock time-set controller.
// Field limits, state and field encodings, and capture sanitising.
package clock_pkg;

    localparam int TIME_W = 6;

    localparam logic [TIME_W-1:0] HRS_MAX = 6'd23;
    localparam logic [TIME_W-1:0] MIN_MAX = 6'd59;

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_SET_H  = 3'd1,
        ST_SET_M  = 3'd2,
        ST_SET_S  = 3'd3,
        ST_COMMIT = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        FLD_NONE = 2'd0,
        FLD_HRS  = 2'd1,
        FLD_MINS = 2'd2,
        FLD_SECS = 2'd3
    } field_e;

    // Out-of-range live values would break the wrap arithmetic, so they start at 0.
    function automatic logic [TIME_W-1:0] capture_val(input logic [TIME_W-1:0] v,
                                                      input logic [TIME_W-1:0] max);
        return (v > max) ? '0 : v;
    endfunction

    function automatic field_e field_of(input state_e st);
        case (st)
            ST_SET_H: return FLD_HRS;
            ST_SET_M: return FLD_MINS;
            ST_SET_S: return FLD_SECS;
            default:  return FLD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/field_adj.sv
// Wrap-around up/down step for one time field (0..max).
// Simultaneous inc and dec cancel out.
module field_adj
    import clock_pkg::*;
(
    input  logic [TIME_W-1:0] value_i,
    input  logic [TIME_W-1:0] max_i,
    input  logic              inc_i,
    input  logic              dec_i,
    output logic [TIME_W-1:0] next_o
);

    always_comb begin
        next_o = value_i;
        if (inc_i && !dec_i) begin
            next_o = (value_i == max_i) ? '0 : value_i + 1'b1;
        end else if (dec_i && !inc_i) begin
            next_o = (value_i == '0) ? max_i : value_i - 1'b1;
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-set controller: edits hrs/mins/secs in shadow registers while the
// clock is paused, then commits them with a one-cycle load strobe.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_RUN    | clock counting, buttons other than mode ignored
// ST_SET_H  | editing hours, blink active, idle timeout armed
// ST_SET_M  | editing minutes
// ST_SET_S  | editing seconds
// ST_COMMIT | single cycle: ld_en high with the shadow values
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int BLINK_DIV   = 25000000,
    parameter int TIMEOUT_CYC = 500000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_mode,
    input  logic              btn_inc,
    input  logic              btn_dec,
    input  logic [TIME_W-1:0] cur_hrs,
    input  logic [TIME_W-1:0] cur_mins,
    input  logic [TIME_W-1:0] cur_secs,
    output logic              run_en,
    output logic              ld_en,
    output logic [TIME_W-1:0] ld_hrs,
    output logic [TIME_W-1:0] ld_mins,
    output logic [TIME_W-1:0] ld_secs,
    output logic [1:0]        edit_field,
    output logic              blink
);

    localparam int BLK_W = $clog2(BLINK_DIV);
    localparam int TMO_W = $clog2(TIMEOUT_CYC);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    state_e            state_q, state_d;
    logic              run_en_q, run_en_d;
    logic              ld_en_q, ld_en_d;
    logic [TIME_W-1:0] hrs_q, hrs_d, mins_q, mins_d, secs_q, secs_d;
    field_e            field_q, field_d;
    logic              blink_q, blink_d;
    logic [BLK_W-1:0]  blk_cnt_q, blk_cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;

    logic [TIME_W-1:0] adj_val, adj_max, adj_next;
    logic              in_set, stay_set, any_btn, adj_req;

    always_comb begin
        unique case (state_q)
            ST_SET_M: begin adj_val = mins_q; adj_max = MIN_MAX; end
            ST_SET_S: begin adj_val = secs_q; adj_max = MIN_MAX; end
            default:  begin adj_val = hrs_q;  adj_max = HRS_MAX; end
        endcase
    end

    field_adj u_adj (
        .value_i (adj_val),
        .max_i   (adj_max),
        .inc_i   (btn_inc),
        .dec_i   (btn_dec),
        .next_o  (adj_next)
    );

    assign in_set  = (state_q == ST_SET_H) || (state_q == ST_SET_M) || (state_q == ST_SET_S);
    assign any_btn = btn_mode || btn_inc || btn_dec;
    assign adj_req = btn_inc || btn_dec;

    always_comb begin
        state_d = state_q;
        hrs_d   = hrs_q;
        mins_d  = mins_q;
        secs_d  = secs_q;
        unique case (state_q)
            ST_RUN: begin
                if (btn_mode) begin
                    state_d = ST_SET_H;
                    hrs_d   = capture_val(cur_hrs, HRS_MAX);
                    mins_d  = capture_val(cur_mins, MIN_MAX);
                    secs_d  = capture_val(cur_secs, MIN_MAX);
                end
            end
            ST_SET_H, ST_SET_M, ST_SET_S: begin
                // mode outranks inc/dec, and any button outranks the timeout
                if (btn_mode) begin
                    unique case (state_q)
                        ST_SET_H: state_d = ST_SET_M;
                        ST_SET_M: state_d = ST_SET_S;
                        default:  state_d = ST_COMMIT;
                    endcase
                end else if (adj_req) begin
                    unique case (state_q)
                        ST_SET_H: hrs_d  = adj_next;
                        ST_SET_M: mins_d = adj_next;
                        default:  secs_d = adj_next;
                    endcase
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_COMMIT: state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    assign stay_set = in_set && (state_d != ST_RUN) && (state_d != ST_COMMIT);

    always_comb begin
        run_en_d  = (state_d == ST_RUN);
        ld_en_d   = (state_d == ST_COMMIT);
        field_d   = field_of(state_d);
        tmo_d     = '0;
        blk_cnt_d = '0;
        blink_d   = 1'b0;
        if (in_set && (state_d == state_q) && !any_btn) begin
            tmo_d = tmo_q + 1'b1;
        end
        // Blink phase runs on across SET_M/SET_S; entry from RUN starts it at 0.
        if (stay_set) begin
            if (blk_cnt_q == BLK_LAST) begin
                blk_cnt_d = '0;
                blink_d   = ~blink_q;
            end else begin
                blk_cnt_d = blk_cnt_q + 1'b1;
                blink_d   = blink_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_RUN;
            run_en_q  <= 1'b1;
            ld_en_q   <= 1'b0;
            hrs_q     <= '0;
            mins_q    <= '0;
            secs_q    <= '0;
            field_q   <= FLD_NONE;
            blink_q   <= 1'b0;
            blk_cnt_q <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            run_en_q  <= run_en_d;
            ld_en_q   <= ld_en_d;
            hrs_q     <= hrs_d;
            mins_q    <= mins_d;
            secs_q    <= secs_d;
            field_q   <= field_d;
            blink_q   <= blink_d;
            blk_cnt_q <= blk_cnt_d;
            tmo_q     <= tmo_d;
        end
    end

    assign run_en     = run_en_q;
    assign ld_en      = ld_en_q;
    assign ld_hrs     = hrs_q;
    assign ld_mins    = mins_q;
    assign ld_secs    = secs_q;
    assign edit_field = field_q;
    assign blink      = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed literal checks plus random button traffic
// compared every cycle against an abstract model of the edit session.
module tb_clock_set_ctrl;

    localparam int BLINK_DIV   = 2;
    localparam int TIMEOUT_CYC = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
    logic [5:0] cur_hrs = '0, cur_mins = '0, cur_secs = '0;
    logic       run_en, ld_en, blink;
    logic [5:0] ld_hrs, ld_mins, ld_secs;
    logic [1:0] edit_field;

    int n_tests = 0;
    int n_fail  = 0;
    int ld_pulses = 0;

    clock_set_ctrl #(.BLINK_DIV(BLINK_DIV), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .btn_dec    (btn_dec),
        .cur_hrs    (cur_hrs),
        .cur_mins   (cur_mins),
        .cur_secs   (cur_secs),
        .run_en     (run_en),
        .ld_en      (ld_en),
        .ld_hrs     (ld_hrs),
        .ld_mins    (ld_mins),
        .ld_secs    (ld_secs),
        .edit_field (edit_field),
        .blink      (blink)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: 0 = running, 1..3 = editing that field, 4 = committing.
    int  m_mode = 0;
    int  m_t[3] = '{0, 0, 0};
    int  m_idle = 0;
    int  m_phase = 0;
    bit  m_blink = 0;
    bit  m_valid = 0;
    bit  m_fresh = 0;

    function automatic int lim(input int f);
        return (f == 0) ? 23 : 59;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_mode = 0; m_t = '{0, 0, 0}; m_idle = 0; m_phase = 0; m_blink = 0;
            m_valid = 1; m_fresh = 1;
        end else if (m_valid) begin
            if (m_mode == 0) begin
                if (btn_mode) begin
                    m_mode = 1; m_idle = 0; m_phase = 0; m_blink = 0; m_fresh = 0;
                    m_t[0] = (int'(cur_hrs)  > 23) ? 0 : int'(cur_hrs);
                    m_t[1] = (int'(cur_mins) > 59) ? 0 : int'(cur_mins);
                    m_t[2] = (int'(cur_secs) > 59) ? 0 : int'(cur_secs);
                end
            end else if (m_mode == 4) begin
                m_mode = 0;
            end else begin
                int f;
                bit leave;
                f = m_mode - 1;
                leave = 0;
                if (btn_mode) begin
                    m_mode = m_mode + 1; m_idle = 0;
                    leave = (m_mode == 4);
                end else if (btn_inc || btn_dec) begin
                    if (btn_inc && !btn_dec) m_t[f] = (m_t[f] + 1) % (lim(f) + 1);
                    if (btn_dec && !btn_inc) m_t[f] = (m_t[f] + lim(f)) % (lim(f) + 1);
                    m_idle = 0;
                end else if (m_idle == TIMEOUT_CYC - 1) begin
                    m_mode = 0; m_idle = 0; leave = 1;
                end else begin
                    m_idle++;
                end
                if (leave) begin
                    m_phase = 0; m_blink = 0;
                end else begin
                    m_phase++;
                    if (m_phase == BLINK_DIV) begin m_phase = 0; m_blink = ~m_blink; end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (ld_en) ld_pulses++;
        if (m_valid) begin
            chk("run_en", run_en, (m_mode == 0) ? 1 : 0);
            chk("ld_en", ld_en, (m_mode == 4) ? 1 : 0);
            chk("edit_field", edit_field, (m_mode >= 1 && m_mode <= 3) ? m_mode : 0);
            chk("blink", blink, m_blink);
            if (m_mode != 0 || m_fresh) begin
                chk("ld_hrs", ld_hrs, m_t[0]);
                chk("ld_mins", ld_mins, m_t[1]);
                chk("ld_secs", ld_secs, m_t[2]);
            end
        end
    end

    task automatic cyc(input bit m, input bit i, input bit d);
        btn_mode = m; btn_inc = i; btn_dec = d;
        @(posedge clk);
        #1;
        btn_mode = 0; btn_inc = 0; btn_dec = 0;
    endtask

    task automatic set_cur(input int h, input int mi, input int s);
        cur_hrs = 6'(h); cur_mins = 6'(mi); cur_secs = 6'(s);
    endtask

    initial begin
        int p0;
        int rate;
        // Reset for two cycles
        rst = 0;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("rst_run_en", run_en, 1);
        chk("rst_ld_en", ld_en, 0);
        chk("rst_field", edit_field, 0);
        chk("rst_blink", blink, 0);
        chk("rst_ld_hrs", ld_hrs, 0);
        rst = 1;
        cyc(0, 0, 0);

        // Capture and full edit/commit sequence
        set_cur(12, 34, 56);
        p0 = ld_pulses;
        cyc(1, 0, 0);
        chk("enter_run_en", run_en, 0);
        chk("enter_field", edit_field, 1);
        chk("enter_hrs", ld_hrs, 12);
        chk("enter_mins", ld_mins, 34);
        chk("enter_secs", ld_secs, 56);
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        chk("inc2_hrs", ld_hrs, 14);
        cyc(1, 0, 0);
        chk("field_m", edit_field, 2);
        cyc(1, 0, 0);
        chk("field_s", edit_field, 3);
        cyc(1, 0, 0);
        chk("commit_ld_en", ld_en, 1);
        chk("commit_run_en", run_en, 0);
        chk("commit_field", edit_field, 0);
        chk("commit_hms", {ld_hrs, ld_mins, ld_secs}, {6'd14, 6'd34, 6'd56});
        cyc(0, 0, 0);
        chk("post_commit_ld_en", ld_en, 0);
        chk("post_commit_run_en", run_en, 1);
        chk("commit_pulses", ld_pulses - p0, 1);

        // Wrap boundaries and out-of-range capture
        set_cur(23, 0, 61);
        cyc(1, 0, 0);
        chk("cap_secs_oor", ld_secs, 0);
        cyc(0, 1, 0);
        chk("hrs_wrap_up", ld_hrs, 0);
        cyc(0, 0, 1);
        chk("hrs_wrap_dn", ld_hrs, 23);
        cyc(0, 1, 1);
        chk("hrs_inc_dec", ld_hrs, 23);
        cyc(1, 0, 0);
        cyc(0, 0, 1);
        chk("mins_wrap_dn", ld_mins, 59);
        cyc(0, 1, 0);
        chk("mins_wrap_up", ld_mins, 0);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        cyc(0, 0, 0);

        // Mode beats inc, then reset mid-edit
        set_cur(5, 30, 10);
        p0 = ld_pulses;
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        cyc(1, 1, 0);
        chk("mode_prio_field", edit_field, 3);
        chk("mode_prio_mins", ld_mins, 30);
        rst = 0;
        cyc(0, 0, 0);
        rst = 1;
        chk("midrst_run_en", run_en, 1);
        chk("midrst_field", edit_field, 0);
        chk("midrst_hrs", ld_hrs, 0);
        cyc(0, 0, 0);
        chk("midrst_pulses", ld_pulses - p0, 0);

        // Idle timeout with blink phases
        set_cur(1, 2, 3);
        p0 = ld_pulses;
        cyc(1, 0, 0);
        chk("tmo_blink_0", blink, 0);
        for (int k = 1; k < TIMEOUT_CYC; k++) begin
            cyc(0, 0, 0);
            chk("tmo_field", edit_field, 1);
            chk("tmo_blink", blink, (k / BLINK_DIV) % 2);
        end
        cyc(0, 0, 0);
        chk("tmo_run_en", run_en, 1);
        chk("tmo_field_end", edit_field, 0);
        chk("tmo_blink_end", blink, 0);
        cyc(0, 0, 0);
        chk("tmo_pulses", ld_pulses - p0, 0);

        // Random traffic checked by the per-cycle model
        for (int blk = 0; blk < 16; blk++) begin
            rate = (blk % 4 == 0) ? 3 : (blk % 4 == 1) ? 10 : (blk % 4 == 2) ? 25 : 50;
            for (int c = 0; c < 250; c++) begin
                set_cur($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63));
                rst = ($urandom_range(0, 299) != 0);
                cyc($urandom_range(0, 99) < rate / 2 + 2,
                    $urandom_range(0, 99) < rate,
                    $urandom_range(0, 99) < rate);
            end
        end
        rst = 1;
        cyc(0, 0, 0);
        cyc(0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
